// File: rtl/sensor_node_pkg.sv
// rtl/sensor_node_pkg.sv - shared packet constants, FSM state type and checksum helper
package sensor_node_pkg;

  localparam logic [7:0] PKT_HEADER   = 8'hA5;
  localparam int         PKT_OVERHEAD = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEQ,
    ST_PAYLOAD,
    ST_CSUM
  } pkt_state_t;

  // Byte that brings the running packet sum to zero mod 256.
  function automatic logic [7:0] csum_byte(input logic [7:0] sum);
    return 8'(~sum + 8'd1);
  endfunction

endpackage

// File: rtl/sensor_packetizer_if.sv
// rtl/sensor_packetizer_if.sv - valid/ready byte stream towards the radio transmit stage
interface sensor_packetizer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous FIFO with occupancy count and simultaneous push/pop
module sample_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sensor_packetizer.sv
// rtl/sensor_packetizer.sv - paces sensor strobes, buffers readings and frames them into checksummed byte packets
module sensor_packetizer
  import sensor_node_pkg::*;
#(
  parameter int SAMPLE_DIV      = 1000,
  parameter int SAMPLES_PER_PKT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                sensor_en,
  input  logic [7:0]          sensor_data,
  sensor_packetizer_if.master tx,
  output logic                overrun
);

  localparam int DEPTH = 2 * SAMPLES_PER_PKT;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(SAMPLES_PER_PKT + 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             div_wrap;
  logic             cap_q, cap_d;

  pkt_state_t       state_q, state_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       sum_q, sum_d;
  logic [PW-1:0]    pay_cnt_q, pay_cnt_d;

  logic             byte_valid;
  logic [7:0]       byte_data;

  logic             fifo_pop;
  logic [7:0]       fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;

  assign div_wrap  = (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign sensor_en = rst_n && start && div_wrap;

  // The sensor presents its reading one cycle after the strobe.
  assign cap_d   = sensor_en;
  assign overrun = cap_q && fifo_full && !fifo_pop;

  always_comb begin
    div_d = '0;
    if (start) div_d = div_wrap ? '0 : div_q + 1'b1;
  end

  sample_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (cap_q),
    .push_data_i (sensor_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    sum_d      = sum_q;
    pay_cnt_d  = pay_cnt_q;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    fifo_pop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fifo_count >= CW'(SAMPLES_PER_PKT)) state_d = ST_HDR;
      end
      ST_HDR: begin
        byte_valid = 1'b1;
        byte_data  = PKT_HEADER;
        if (tx.tx_ready) begin
          sum_d   = PKT_HEADER;
          state_d = ST_SEQ;
        end
      end
      ST_SEQ: begin
        byte_valid = 1'b1;
        byte_data  = seq_q;
        if (tx.tx_ready) begin
          sum_d     = sum_q + seq_q;
          pay_cnt_d = '0;
          state_d   = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        byte_valid = 1'b1;
        byte_data  = fifo_head;
        if (tx.tx_ready) begin
          fifo_pop = !fifo_empty;
          sum_d    = sum_q + fifo_head;
          if (pay_cnt_q == PW'(SAMPLES_PER_PKT - 1)) begin
            state_d = ST_CSUM;
          end else begin
            pay_cnt_d = pay_cnt_q + 1'b1;
          end
        end
      end
      ST_CSUM: begin
        byte_valid = 1'b1;
        byte_data  = csum_byte(sum_q);
        if (tx.tx_ready) begin
          seq_d   = seq_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx.tx_valid = byte_valid;
  assign tx.tx_data  = byte_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q     <= '0;
      cap_q     <= 1'b0;
      state_q   <= ST_IDLE;
      seq_q     <= 8'h00;
      sum_q     <= 8'h00;
      pay_cnt_q <= '0;
    end else begin
      div_q     <= div_d;
      cap_q     <= cap_d;
      state_q   <= state_d;
      seq_q     <= seq_d;
      sum_q     <= sum_d;
      pay_cnt_q <= pay_cnt_d;
    end
  end

endmodule

// File: tb/tb_sensor_packetizer.sv
// tb/tb_sensor_packetizer.sv - scoreboard bench for sensor_packetizer
module tb_sensor_packetizer;

  localparam int DIV   = 4;
  localparam int N     = 4;
  localparam int DEPTH = 2 * N;
  localparam int TMO   = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sensor_en;
  logic       overrun;
  logic [7:0] sensor_data;

  sensor_packetizer_if tx_if ();

  sensor_packetizer #(
    .SAMPLE_DIV      (DIV),
    .SAMPLES_PER_PKT (N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sensor_en   (sensor_en),
    .sensor_data (sensor_data),
    .tx          (tx_if),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sensor: registered reading, zero when not enabled.
  byte unsigned vq[$];
  always @(posedge clk) begin
    if (sensor_en) begin
      if (vq.size() > 0) sensor_data <= vq.pop_front();
      else sensor_data <= 8'($urandom_range(1, 255));
    end else begin
      sensor_data <= 8'h00;
    end
  end

  byte unsigned mq[$];
  int         midx, mdiv;
  logic [7:0] mseq, msum, obs_sum, prev_data, exp_b;
  bit         mcap, prev_hold, gap_needed, xfer, exp_en;
  int         pkt_count, cap_count, ov_count, en_count;
  int         first_en_cyc, hdr_cyc, csum_cyc, hdr_caps;
  logic [7:0] last_seq, prev_seq;
  logic [7:0] last_pkt [N+3];

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      midx = 0; mdiv = 0; mseq = 8'h00; msum = 8'h00; obs_sum = 8'h00;
      mcap = 0; prev_hold = 0; gap_needed = 0;
      pkt_count = 0; cap_count = 0; ov_count = 0; en_count = 0; first_en_cyc = -1;
    end else begin
      exp_en = start && (mdiv == DIV - 1);
      checks++;
      if (sensor_en !== exp_en) begin
        errors++;
        $display("FAIL sensor_en cyc=%0d got=%b exp=%b", cyc, sensor_en, exp_en);
      end
      if (sensor_en) begin
        en_count++;
        if (first_en_cyc < 0) first_en_cyc = cyc;
      end
      mdiv = start ? ((mdiv == DIV - 1) ? 0 : mdiv + 1) : 0;

      if (prev_hold) begin
        checks++;
        if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== prev_data) begin
          errors++;
          $display("FAIL hold cyc=%0d got valid=%b data=%h exp valid=1 data=%h",
                   cyc, tx_if.tx_valid, tx_if.tx_data, prev_data);
        end
      end
      if (gap_needed) begin
        checks++;
        if (tx_if.tx_valid !== 1'b0) begin
          errors++;
          $display("FAIL idle_gap cyc=%0d got valid=%b exp=0", cyc, tx_if.tx_valid);
        end
      end
      gap_needed = 0;

      xfer = tx_if.tx_valid && tx_if.tx_ready;
      if (xfer) begin
        if (midx == 0) begin
          exp_b = 8'hA5; hdr_cyc = cyc; hdr_caps = cap_count; msum = 8'h00; obs_sum = 8'h00;
        end else if (midx == 1) begin
          exp_b = mseq;
        end else if (midx < N + 2) begin
          checks++;
          if (mq.size() == 0) begin
            errors++;
            $display("FAIL payload_underflow cyc=%0d got data=%h exp no byte", cyc, tx_if.tx_data);
            exp_b = 8'h00;
          end else begin
            exp_b = mq.pop_front();
          end
        end else begin
          exp_b = 8'(~msum + 8'd1);
        end
        checks++;
        if (tx_if.tx_data !== exp_b) begin
          errors++;
          $display("FAIL byte idx=%0d cyc=%0d got=%h exp=%h", midx, cyc, tx_if.tx_data, exp_b);
        end
        last_pkt[midx] = tx_if.tx_data;
        obs_sum = obs_sum + tx_if.tx_data;
        if (midx == 1) begin
          prev_seq = last_seq;
          last_seq = tx_if.tx_data;
        end
        if (midx == N + 2) begin
          checks++;
          if (obs_sum !== 8'h00) begin
            errors++;
            $display("FAIL pkt_sum cyc=%0d got=%h exp=00", cyc, obs_sum);
          end
          mseq++; midx = 0; pkt_count++; csum_cyc = cyc; gap_needed = 1;
        end else begin
          msum = msum + exp_b;
          midx++;
        end
      end

      checks++;
      if (mcap) begin
        cap_count++;
        if (mq.size() == DEPTH) begin
          ov_count++;
          if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse cyc=%0d got=%b exp=1", cyc, overrun);
          end
        end else begin
          mq.push_back(sensor_data);
          if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_capture cyc=%0d got=%b exp=0", cyc, overrun);
          end
        end
      end else if (overrun !== 1'b0) begin
        errors++;
        $display("FAIL overrun_idle cyc=%0d got=%b exp=0", cyc, overrun);
      end
      mcap      = sensor_en;
      prev_hold = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data = tx_if.tx_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0; tx_if.tx_ready = 1'b0;
    vq.delete();
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b1; tx_if.tx_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks += 4;
    if (sensor_en !== 1'b0) begin errors++; $display("FAIL reset_sensor_en got=%b exp=0", sensor_en); end
    if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_if.tx_valid); end
    if (tx_if.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_if.tx_data); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_tx_valid got=%b exp=0", tx_if.tx_valid); end
    tick(1);
  endtask

  task automatic test_basic();
    logic [7:0] exp_pkt [7] = '{8'hA5, 8'h00, 8'h0A, 8'h14, 8'h1E, 8'h28, 8'hF7};
    int st_cyc, t;
    do_reset();
    vq.push_back(8'd10); vq.push_back(8'd20); vq.push_back(8'd30); vq.push_back(8'd40);
    tx_if.tx_ready = 1'b1; start = 1'b1; st_cyc = cyc;
    t = 0;
    while (pkt_count < 1 && t < TMO) begin tick(1); t++; end
    checks++;
    if (pkt_count < 1) begin errors++; $display("FAIL basic_timeout got pkts=%0d exp=1", pkt_count); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (last_pkt[i] !== exp_pkt[i]) begin
        errors++; $display("FAIL basic_byte%0d got=%h exp=%h", i, last_pkt[i], exp_pkt[i]);
      end
    end
    checks += 3;
    if (first_en_cyc - st_cyc !== DIV - 1) begin
      errors++; $display("FAIL first_strobe got=%0d exp=%0d", first_en_cyc - st_cyc, DIV - 1);
    end
    if (hdr_cyc - first_en_cyc !== 3 * DIV + 3) begin
      errors++; $display("FAIL hdr_latency got=%0d exp=%0d", hdr_cyc - first_en_cyc, 3 * DIV + 3);
    end
    if (csum_cyc - hdr_cyc !== N + 2) begin
      errors++; $display("FAIL pkt_span got=%0d exp=%0d", csum_cyc - hdr_cyc, N + 2);
    end
    start = 1'b0;
    tick(4);
  endtask

  task automatic test_backpressure();
    int t;
    do_reset();
    vq.push_back(8'd10); vq.push_back(8'd20); vq.push_back(8'd30); vq.push_back(8'd40);
    tx_if.tx_ready = 1'b1; start = 1'b1;
    t = 0;
    while (midx != 3 && t < TMO) begin tick(1); t++; end
    checks++;
    if (midx != 3) begin errors++; $display("FAIL bp_timeout got idx=%0d exp=3", midx); end
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'h14) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%b data=%h exp valid=1 data=14", i, tx_if.tx_valid, tx_if.tx_data);
      end
    end
    @(posedge clk); #1;
    tx_if.tx_ready = 1'b1;
    t = 0;
    while (pkt_count < 1 && t < TMO) begin tick(1); t++; end
    checks += 2;
    if (last_pkt[3] !== 8'h14) begin errors++; $display("FAIL bp_byte got=%h exp=14", last_pkt[3]); end
    if (last_pkt[N+2] !== 8'hF7) begin errors++; $display("FAIL bp_csum got=%h exp=F7", last_pkt[N+2]); end
    start = 1'b0;
    tick(4);
  endtask

  task automatic test_overrun();
    int t;
    do_reset();
    tx_if.tx_ready = 1'b0; start = 1'b1;
    t = 0;
    while (cap_count < 9 && t < TMO) begin tick(1); t++; end
    checks += 2;
    if (cap_count < 9) begin errors++; $display("FAIL ovr_timeout got caps=%0d exp=9", cap_count); end
    if (ov_count !== 1) begin errors++; $display("FAIL ovr_count got=%0d exp=1", ov_count); end
    @(negedge clk);
    checks++;
    if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'hA5) begin
      errors++; $display("FAIL ovr_hdr_hold got valid=%b data=%h exp valid=1 data=A5", tx_if.tx_valid, tx_if.tx_data);
    end
    @(posedge clk); #1;
    start = 1'b0; tx_if.tx_ready = 1'b1;
    t = 0;
    while (pkt_count < 2 && t < TMO) begin tick(1); t++; end
    tick(6);
    checks += 2;
    if (pkt_count !== 2) begin errors++; $display("FAIL ovr_drain got pkts=%0d exp=2", pkt_count); end
    if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL ovr_idle got valid=%b exp=0", tx_if.tx_valid); end
  endtask

  task automatic test_start_drop();
    int t, en0;
    logic [7:0] r0, r1;
    do_reset();
    tx_if.tx_ready = 1'b0; start = 1'b1;
    t = 0;
    while (cap_count < 6 && t < TMO) begin tick(1); t++; end
    start = 1'b0; tx_if.tx_ready = 1'b1; en0 = en_count;
    tick(40);
    checks += 3;
    if (pkt_count !== 1) begin errors++; $display("FAIL drop_pkt got pkts=%0d exp=1", pkt_count); end
    if (en_count !== en0) begin errors++; $display("FAIL drop_strobes got=%0d exp=%0d", en_count, en0); end
    if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL drop_idle got valid=%b exp=0", tx_if.tx_valid); end
    r0 = (mq.size() > 0) ? mq[0] : 8'h00;
    r1 = (mq.size() > 1) ? mq[1] : 8'h00;
    start = 1'b1;
    t = 0;
    while (pkt_count < 2 && t < TMO) begin tick(1); t++; end
    checks += 3;
    if (pkt_count < 2) begin errors++; $display("FAIL drop_resume got pkts=%0d exp=2", pkt_count); end
    if (last_pkt[2] !== r0) begin errors++; $display("FAIL drop_resid0 got=%h exp=%h", last_pkt[2], r0); end
    if (last_pkt[3] !== r1) begin errors++; $display("FAIL drop_resid1 got=%h exp=%h", last_pkt[3], r1); end
    start = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset();
    tx_if.tx_ready = 1'b1; start = 1'b1;
    t = 0;
    while (midx != 3 && t < TMO) begin tick(1); t++; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", tx_if.tx_valid); end
    t = 0;
    while (pkt_count < 1 && t < TMO) begin tick(1); t++; end
    checks += 3;
    if (pkt_count < 1) begin errors++; $display("FAIL rmid_timeout got pkts=%0d exp=1", pkt_count); end
    if (last_seq !== 8'h00) begin errors++; $display("FAIL rmid_seq got=%h exp=00", last_seq); end
    if (hdr_caps < N) begin errors++; $display("FAIL rmid_fresh got caps=%0d exp>=%0d", hdr_caps, N); end
    start = 1'b0;
    tick(4);
  endtask

  task automatic test_seq_wrap();
    int t;
    do_reset();
    tx_if.tx_ready = 1'b1; start = 1'b1;
    t = 0;
    while (pkt_count < 257 && t < 257 * 4 * DIV + 400) begin tick(1); t++; end
    checks += 4;
    if (pkt_count < 257) begin errors++; $display("FAIL wrap_timeout got pkts=%0d exp=257", pkt_count); end
    if (prev_seq !== 8'hFF) begin errors++; $display("FAIL wrap_seq255 got=%h exp=FF", prev_seq); end
    if (last_seq !== 8'h00) begin errors++; $display("FAIL wrap_seq0 got=%h exp=00", last_seq); end
    if (ov_count !== 0) begin errors++; $display("FAIL wrap_overrun got=%0d exp=0", ov_count); end
    start = 1'b0;
    tick(4);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tx_if.tx_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_start_drop();
    test_reset_mid();
    test_seq_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got cyc=%0d exp finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
